// File: rtl/kmeans_pkg.sv
// Shared widths, controller state encoding and the coordinate saturation helper
// for the k-means centroid update stage.
package kmeans_pkg;

  localparam int CORD_W     = 13;
  localparam int ACC_CORD_W = 22;
  localparam int CNT_W      = 10;
  localparam int COORD_NUM  = 7;
  localparam int CENT_NUM   = 8;
  localparam int IDX_W      = 3;
  localparam int BIT_CNT_W  = 5;
  localparam int DATA_W     = COORD_NUM * CORD_W;
  localparam int ACC_W      = COORD_NUM * ACC_CORD_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIVIDE,
    WRITE,
    DONE
  } nm_state_t;

  // Any quotient that does not fit a coordinate clamps to the largest coordinate.
  function automatic logic [CORD_W-1:0] sat_coord(input logic [ACC_CORD_W-1:0] quotient);
    if (quotient[ACC_CORD_W-1:CORD_W] != '0) return '1;
    return quotient[CORD_W-1:0];
  endfunction

endpackage

// File: rtl/new_means_calc_seq_divider.sv
// Sequential restoring divider: one quotient bit per step, MSB first.
// After ACC_CORD_W steps following a load, quotient holds floor(dividend/divisor).
module seq_divider #(
  parameter int ACC_CORD_W = 22,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ACC_CORD_W-1:0] dividend,
  input  logic [CNT_W-1:0]      divisor,
  output logic [ACC_CORD_W-1:0] quotient
);

  logic [ACC_CORD_W-1:0] dq_q, dq_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [CNT_W-1:0]      dvs_q, dvs_d;
  logic [CNT_W:0]        shifted;

  // dq holds the unconsumed dividend bits in its upper part and the quotient
  // bits shifted in from the bottom; after the last step it is the quotient.
  always_comb begin
    dq_d    = dq_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    shifted = {rem_q, dq_q[ACC_CORD_W-1]};
    if (load) begin
      dq_d  = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = shifted[CNT_W-1:0] - dvs_q;
        dq_d  = {dq_q[ACC_CORD_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[CNT_W-1:0];
        dq_d  = {dq_q[ACC_CORD_W-2:0], 1'b0};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_q  <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient = dq_q;

endmodule

// File: rtl/new_means_calc.sv
// Centroid update: divides each centroid's coordinate sums by its point count
// with seven parallel dividers and writes the eight results back one by one.
module new_means_calc
  import kmeans_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ACC_W-1:0]  accum_1,
  input  logic [ACC_W-1:0]  accum_2,
  input  logic [ACC_W-1:0]  accum_3,
  input  logic [ACC_W-1:0]  accum_4,
  input  logic [ACC_W-1:0]  accum_5,
  input  logic [ACC_W-1:0]  accum_6,
  input  logic [ACC_W-1:0]  accum_7,
  input  logic [ACC_W-1:0]  accum_8,
  input  logic [CNT_W-1:0]  cnt_1,
  input  logic [CNT_W-1:0]  cnt_2,
  input  logic [CNT_W-1:0]  cnt_3,
  input  logic [CNT_W-1:0]  cnt_4,
  input  logic [CNT_W-1:0]  cnt_5,
  input  logic [CNT_W-1:0]  cnt_6,
  input  logic [CNT_W-1:0]  cnt_7,
  input  logic [CNT_W-1:0]  cnt_8,
  input  logic [DATA_W-1:0] centroid_reg_1,
  input  logic [DATA_W-1:0] centroid_reg_2,
  input  logic [DATA_W-1:0] centroid_reg_3,
  input  logic [DATA_W-1:0] centroid_reg_4,
  input  logic [DATA_W-1:0] centroid_reg_5,
  input  logic [DATA_W-1:0] centroid_reg_6,
  input  logic [DATA_W-1:0] centroid_reg_7,
  input  logic [DATA_W-1:0] centroid_reg_8,
  output logic [IDX_W-1:0]  cent_cnt,
  output logic [DATA_W-1:0] new_centroid,
  output logic              new_centroid_valid,
  output logic              busy,
  output logic              done
);

  logic [ACC_W-1:0]  accum_arr [CENT_NUM];
  logic [CNT_W-1:0]  cnt_arr   [CENT_NUM];
  logic [DATA_W-1:0] creg_arr  [CENT_NUM];

  assign accum_arr = '{accum_1, accum_2, accum_3, accum_4, accum_5, accum_6, accum_7, accum_8};
  assign cnt_arr   = '{cnt_1, cnt_2, cnt_3, cnt_4, cnt_5, cnt_6, cnt_7, cnt_8};
  assign creg_arr  = '{centroid_reg_1, centroid_reg_2, centroid_reg_3, centroid_reg_4,
                       centroid_reg_5, centroid_reg_6, centroid_reg_7, centroid_reg_8};

  nm_state_t             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  bypass_q, bypass_d;
  logic [IDX_W-1:0]      cent_cnt_q, cent_cnt_d;
  logic [DATA_W-1:0]     new_centroid_q, new_centroid_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic                  div_load, div_step;
  logic [ACC_W-1:0]      accum_sel;
  logic [CNT_W-1:0]      cnt_sel;
  logic [DATA_W-1:0]     creg_sel;
  logic [ACC_CORD_W-1:0] quot [COORD_NUM];
  logic [DATA_W-1:0]     sat_vec;

  assign accum_sel = accum_arr[idx_q];
  assign cnt_sel   = cnt_arr[idx_q];
  assign creg_sel  = creg_arr[idx_q];

  for (genvar c = 0; c < COORD_NUM; c++) begin : g_div
    seq_divider #(
      .ACC_CORD_W(ACC_CORD_W),
      .CNT_W     (CNT_W)
    ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (div_load),
      .step    (div_step),
      .dividend(accum_sel[c*ACC_CORD_W +: ACC_CORD_W]),
      .divisor (cnt_sel),
      .quotient(quot[c])
    );
  end

  always_comb begin
    sat_vec = '0;
    for (int c = 0; c < COORD_NUM; c++) begin
      sat_vec[c*CORD_W +: CORD_W] = sat_coord(quot[c]);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bit_cnt_d      = bit_cnt_q;
    bypass_d       = bypass_q;
    cent_cnt_d     = cent_cnt_q;
    new_centroid_d = new_centroid_q;
    valid_d        = 1'b0;
    done_d         = 1'b0;
    div_load       = 1'b0;
    div_step       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        div_load  = 1'b1;
        bit_cnt_d = '0;
        bypass_d  = (cnt_sel == '0);
        state_d   = (cnt_sel == '0) ? WRITE : DIVIDE;
      end
      DIVIDE: begin
        div_step = 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(ACC_CORD_W - 1)) state_d = WRITE;
        else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      WRITE: begin
        valid_d        = 1'b1;
        cent_cnt_d     = idx_q;
        new_centroid_d = bypass_q ? creg_sel : sat_vec;
        if (idx_q == IDX_W'(CENT_NUM - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      bit_cnt_q      <= '0;
      bypass_q       <= 1'b0;
      cent_cnt_q     <= '0;
      new_centroid_q <= '0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      bit_cnt_q      <= bit_cnt_d;
      bypass_q       <= bypass_d;
      cent_cnt_q     <= cent_cnt_d;
      new_centroid_q <= new_centroid_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
    end
  end

  assign cent_cnt           = cent_cnt_q;
  assign new_centroid       = new_centroid_q;
  assign new_centroid_valid = valid_q;
  assign done               = done_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_new_means_calc.sv
// Scoreboard bench for new_means_calc: stimulus queues expected writes and
// done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_new_means_calc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [153:0] acc  [8];
  logic [9:0]   cnt  [8];
  logic [90:0]  creg [8];
  logic [2:0]   cent_cnt;
  logic [90:0]  new_centroid;
  logic         new_centroid_valid;
  logic         busy;
  logic         done;

  int exp_c [8][7];

  new_means_calc dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .accum_1(acc[0]), .accum_2(acc[1]), .accum_3(acc[2]), .accum_4(acc[3]),
    .accum_5(acc[4]), .accum_6(acc[5]), .accum_7(acc[6]), .accum_8(acc[7]),
    .cnt_1(cnt[0]), .cnt_2(cnt[1]), .cnt_3(cnt[2]), .cnt_4(cnt[3]),
    .cnt_5(cnt[4]), .cnt_6(cnt[5]), .cnt_7(cnt[6]), .cnt_8(cnt[7]),
    .centroid_reg_1(creg[0]), .centroid_reg_2(creg[1]), .centroid_reg_3(creg[2]),
    .centroid_reg_4(creg[3]), .centroid_reg_5(creg[4]), .centroid_reg_6(creg[5]),
    .centroid_reg_7(creg[6]), .centroid_reg_8(creg[7]),
    .cent_cnt(cent_cnt), .new_centroid(new_centroid),
    .new_centroid_valid(new_centroid_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [90:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  wr_t cur_wr;
  int  tests = 0;
  int  fails = 0;
  int  valid_seen = 0;
  int  done_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: DUT outputs are registered, so negedge sampling is race free.
  always @(negedge clk) begin
    if (new_centroid_valid === 1'b1) begin
      valid_seen++;
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got index %0d, expected no write (cycle %0d)", cent_cnt, cyc);
      end else begin
        cur_wr = wq.pop_front();
        check($sformatf("write_idx_%0d", cur_wr.idx), cent_cnt, cur_wr.idx);
        check($sformatf("write_data_%0d", cur_wr.idx), new_centroid, cur_wr.data);
        check($sformatf("write_cycle_%0d", cur_wr.idx), cyc, cur_wr.cyc);
      end
    end
    if (done === 1'b1) begin
      done_seen++;
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
      end else begin
        check("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic set_acc(input int k, input int c, input int v);
    acc[k][c*22 +: 22] = 22'(v);
  endtask

  function automatic logic [90:0] pack(input int r);
    logic [90:0] v = '0;
    for (int c = 0; c < 7; c++) v[c*13 +: 13] = 13'(exp_c[r][c]);
    return v;
  endfunction

  // Latency model: 24 cycles per dividing centroid, 2 per zero-count centroid.
  task automatic expect_run(input int t);
    int cur = t;
    for (int k = 0; k < 8; k++) begin
      cur += (cnt[k] == 10'd0) ? 2 : 24;
      wq.push_back(wr_t'{cyc: cur, idx: 3'(k), data: pack(k)});
    end
    dq.push_back(cur + 1);
  endtask

  // Pulses start for one edge; t is the cycle number of the sampling edge.
  task automatic do_start(output int t);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input string name, input int done0, input int valid0);
    for (int i = 0; i < 400 && done_seen == done0; i++) @(posedge clk);
    check({name, "_done_pulses"}, done_seen, done0 + 1);
    repeat (30) @(posedge clk);
    check({name, "_strobes"}, valid_seen, valid0 + 8);
    check({name, "_queue_empty"}, wq.size(), 0);
    check({name, "_not_busy"}, busy, 1'b0);
  endtask

  task automatic cfg_exact();
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 10'd1; creg[k] = '0;
      for (int c = 0; c < 7; c++) begin
        set_acc(k, c, k * 10);
        exp_c[k][c] = k * 10;
      end
    end
    cnt[0] = 10'd4;
    for (int c = 0; c < 7; c++) begin
      set_acc(0, c, 400);
      exp_c[0][c] = 100;
    end
  endtask

  task automatic cfg_mixed();
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 10'd2; creg[k] = '0;
      for (int c = 0; c < 7; c++) begin
        set_acc(k, c, 2 * (k * 7 + c) + 1);
        exp_c[k][c] = k * 7 + c;
      end
    end
    cnt[1] = 10'd1;
    for (int c = 0; c < 7; c++) begin set_acc(1, c, 100 + c); exp_c[1][c] = 100 + c; end
    set_acc(1, 0, 4194303); exp_c[1][0] = 8191;
    set_acc(1, 1, 8192);    exp_c[1][1] = 8191;
    set_acc(1, 2, 8191);    exp_c[1][2] = 8191;
    cnt[2] = 10'd3;
    for (int c = 0; c < 7; c++) begin set_acc(2, c, 3 * c + 2); exp_c[2][c] = c; end
    set_acc(2, 0, 10);   exp_c[2][0] = 3;
    set_acc(2, 6, 1023); exp_c[2][6] = 341;
    cnt[4] = 10'd0;
    for (int c = 0; c < 7; c++) begin
      set_acc(4, c, 12345);
      creg[4][c*13 +: 13] = 13'(c + 1);
      exp_c[4][c] = c + 1;
    end
  endtask

  task automatic cfg_large_div();
    for (int k = 0; k < 8; k++) begin
      cnt[k] = 10'd7; creg[k] = '0;
      for (int c = 0; c < 7; c++) begin
        set_acc(k, c, 7 * (k + c) + 6);
        exp_c[k][c] = k + c;
      end
    end
    cnt[1] = 10'd1023;
    for (int c = 0; c < 7; c++) begin set_acc(1, c, 1023 * c); exp_c[1][c] = c; end
    set_acc(1, 0, 4194303); exp_c[1][0] = 4100;
    set_acc(1, 1, 4194299); exp_c[1][1] = 4099;
    cnt[7] = 10'd0;
    for (int c = 0; c < 7; c++) begin
      creg[7][c*13 +: 13] = 13'h1fff;
      exp_c[7][c] = 8191;
    end
  endtask

  initial begin
    int t;
    int d0, v0;
    for (int k = 0; k < 8; k++) begin acc[k] = '0; cnt[k] = '0; creg[k] = '0; end
    #1;
    check("rst_cent_cnt", cent_cnt, 3'd0);
    check("rst_new_centroid", new_centroid, 91'd0);
    check("rst_valid", new_centroid_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Exact means with all counts nonzero.
    cfg_exact();
    d0 = done_seen; v0 = valid_seen;
    do_start(t);
    expect_run(t);
    wait_done("exact", d0, v0);

    // Saturation, truncation, zero-count bypass, and start ignored while busy.
    cfg_mixed();
    d0 = done_seen; v0 = valid_seen;
    do_start(t);
    expect_run(t);
    repeat (49) @(posedge clk);
    #2 start = 1'b1;
    check("busy_mid_run", busy, 1'b1);
    @(posedge clk); #2 start = 1'b0;
    wait_done("mixed", d0, v0);

    // Large divisor and a zero-count last centroid.
    cfg_large_div();
    d0 = done_seen; v0 = valid_seen;
    do_start(t);
    expect_run(t);
    wait_done("large_div", d0, v0);

    // Reset mid-run, then a complete fresh run.
    cfg_exact();
    do_start(t);
    expect_run(t);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cent_cnt", cent_cnt, 3'd0);
    check("midrst_new_centroid", new_centroid, 91'd0);
    check("midrst_valid", new_centroid_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    wq.delete();
    dq.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    d0 = done_seen; v0 = valid_seen;
    do_start(t);
    expect_run(t);
    wait_done("after_reset", d0, v0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
